universal_shiftreg_param: RTL and testbench

Parametrised universal shift register, the successor to the 4-bit universal shift register. The register width is set by a parameter. It adds rotate, arithmetic-shift-right and clear modes, plus a clock-enable. It also has a self-timed serial burst engine that shifts a programmed number of bits out with busy/done status. It sits between parallel datapath logic and bit-serial links, acting as a generic parallel/serial converter and shifter.

---
 rtl/universal_shiftreg_param.sv | 129 ++++++++++++
 tb/tb_universal_shiftreg_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/universal_shiftreg_param.sv
// universal_shiftreg_param
// Parametrised universal shift register with hold/shift/load/rotate/
// arithmetic-shift/clear modes, a clock enable, and a self-timed serial
// burst engine that shifts a programmed number of bits out in either
// direction, reporting busy while running and a one-cycle done pulse.

module universal_shiftreg_param #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] p_din,
  input  logic             s_left_din,
  input  logic             s_right_din,
  input  logic             burst_start,
  input  logic [CW-1:0]    burst_len,
  input  logic             burst_dir,
  output logic [WIDTH-1:0] p_dout,
  output logic             s_right_dout,
  output logic             s_left_dout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROTL  = 3'b100,
    MODE_ROTR  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_t;

  localparam logic [CW-1:0] WIDTH_LEN = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_LEN   = CW'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] q, q_next;
  logic [CW-1:0]    count, count_next;
  logic             dir, dir_next;     // latched burst direction: 1 = left
  logic             done_next;
  logic             accept;            // burst request taken this edge
  logic             last_shift;        // this edge performs the final burst shift

  assign accept     = en && (state == IDLE) && burst_start && (burst_len != '0);
  assign last_shift = en && (state == SHIFT) && (count == ONE_LEN);

  // State register: the only place the burst FSM state is updated.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: start on an accepted request, finish on the last shift.
  always_comb begin
    // NOTE: defaulting every comb output first keeps unlisted paths from
    // inferring latches.
    state_next = state;
    unique case (state)
      IDLE:  if (accept)     state_next = SHIFT;
      SHIFT: if (last_shift) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Output/datapath logic: next register value, burst count, direction, done.
  always_comb begin
    q_next     = q;
    count_next = count;
    dir_next   = dir;
    done_next  = 1'b0;
    if (en) begin
      if (state == SHIFT) begin
        q_next     = dir ? {q[WIDTH-2:0], s_left_din} : {s_right_din, q[WIDTH-1:1]};
        count_next = count - ONE_LEN;
        done_next  = last_shift;
      end else if (accept) begin
        // Register is untouched on the accept edge; mode is ignored.
        count_next = (burst_len > WIDTH_LEN) ? WIDTH_LEN : burst_len;
        dir_next   = burst_dir;
      end else begin
        case (mode_t'(mode))
          MODE_HOLD:  q_next = q;
          MODE_SHL:   q_next = {q[WIDTH-2:0], s_left_din};
          MODE_SHR:   q_next = {s_right_din, q[WIDTH-1:1]};
          MODE_LOAD:  q_next = p_din;
          MODE_ROTL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
          MODE_ROTR:  q_next = {q[0], q[WIDTH-1:1]};
          MODE_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
          MODE_CLEAR: q_next = '0;
          default:    q_next = q;
        endcase
      end
    end
  end

  // Datapath registers; reset wins over the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      count <= '0;
      dir   <= 1'b0;
      done  <= 1'b0;
    end else begin
      q     <= q_next;
      count <= count_next;
      dir   <= dir_next;
      done  <= done_next;
    end
  end

  assign p_dout       = q;
  assign s_right_dout = q[0];
  assign s_left_dout  = q[WIDTH-1];
  assign busy         = (state == SHIFT);

endmodule

// File: tb/tb_universal_shiftreg_param.sv
// tb_universal_shiftreg_param
// Directed vectors for the 8-bit configuration. The driver applies one
// vector per cycle on the falling edge and queues the hand-computed
// response for the following rising edge; a monitor samples the outputs
// just after each rising edge and compares against the queue head.

module tb_universal_shiftreg_param;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] p_din;
  logic             s_left_din;
  logic             s_right_din;
  logic             burst_start;
  logic [CW-1:0]    burst_len;
  logic             burst_dir;
  logic [WIDTH-1:0] p_dout;
  logic             s_right_dout;
  logic             s_left_dout;
  logic             busy;
  logic             done;

  // Expected {p_dout, busy, done, s_left_dout, s_right_dout}.
  typedef struct {
    string       tag;
    logic [11:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  universal_shiftreg_param #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .p_din        (p_din),
    .s_left_din   (s_left_din),
    .s_right_din  (s_right_din),
    .burst_start  (burst_start),
    .burst_len    (burst_len),
    .burst_dir    (burst_dir),
    .p_dout       (p_dout),
    .s_right_dout (s_right_dout),
    .s_left_dout  (s_left_dout),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got q=%h busy=%b done=%b sl=%b sr=%b, want q=%h busy=%b done=%b sl=%b sr=%b",
               tag, act[11:4], act[3], act[2], act[1], act[0],
               exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Apply one vector, queue the response expected after the next rising edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] pd, input logic sl, input logic sr,
                      input logic bs, input logic [CW-1:0] bl, input logic bd,
                      input logic [7:0] eq, input logic eb, input logic ed);
    exp_t item;
    rst = r; en = e; mode = m; p_din = pd;
    s_left_din = sl; s_right_din = sr;
    burst_start = bs; burst_len = bl; burst_dir = bd;
    item.tag = tag;
    item.exp = {eq, eb, ed, eq[7], eq[0]};
    sb.push_back(item);
    @(negedge clk);
  endtask

  // Monitor: sample just after each rising edge, compare against the queue head.
  initial begin
    exp_t item;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        item = sb.pop_front();
        check(item.tag, {p_dout, busy, done, s_left_dout, s_right_dout}, item.exp);
      end
    end
  end

  // Driver: directed vectors (tag, rst, en, mode, p_din, sl, sr, bs, len, dir, exp q, busy, done).
  initial begin
    int waited;
    rst = 1'b1; en = 1'b1; mode = 3'b000; p_din = '0;
    s_left_din = 1'b0; s_right_din = 1'b0;
    burst_start = 1'b0; burst_len = '0; burst_dir = 1'b0;
    @(negedge clk);

    // Reset and release
    step("reset",       1, 1, 3'b011, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    step("rst_release", 0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    // Basic modes
    step("load_b4",     0, 1, 3'b011, 8'hB4, 0, 0, 0, 0, 0, 8'hB4, 0, 0);
    step("shl_1",       0, 1, 3'b001, 8'h00, 1, 0, 0, 0, 0, 8'h69, 0, 0);
    step("shr_1",       0, 1, 3'b010, 8'h00, 0, 1, 0, 0, 0, 8'hB4, 0, 0);
    step("hold_a",      0, 1, 3'b000, 8'h00, 1, 1, 0, 0, 0, 8'hB4, 0, 0);
    step("hold_b",      0, 1, 3'b000, 8'h00, 1, 1, 0, 0, 0, 8'hB4, 0, 0);
    step("hold_c",      0, 1, 3'b000, 8'h00, 1, 1, 0, 0, 0, 8'hB4, 0, 0);
    // Extended modes
    step("load_81",     0, 1, 3'b011, 8'h81, 0, 0, 0, 0, 0, 8'h81, 0, 0);
    step("rotl",        0, 1, 3'b100, 8'h00, 0, 0, 0, 0, 0, 8'h03, 0, 0);
    step("reload_81",   0, 1, 3'b011, 8'h81, 0, 0, 0, 0, 0, 8'h81, 0, 0);
    step("rotr",        0, 1, 3'b101, 8'h00, 0, 0, 0, 0, 0, 8'hC0, 0, 0);
    step("load_90",     0, 1, 3'b011, 8'h90, 0, 0, 0, 0, 0, 8'h90, 0, 0);
    step("asr",         0, 1, 3'b110, 8'h00, 0, 0, 0, 0, 0, 8'hC8, 0, 0);
    step("clear",       0, 1, 3'b111, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    step("en_low_load", 0, 0, 3'b011, 8'h5A, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    // Right burst of 4 from A5; mode/p_din ignored; second start dropped
    step("load_a5",     0, 1, 3'b011, 8'hA5, 0, 0, 0, 0, 0, 8'hA5, 0, 0);
    step("rb_accept",   0, 1, 3'b011, 8'hFF, 0, 0, 1, 4, 0, 8'hA5, 1, 0);
    step("rb_shift1",   0, 1, 3'b011, 8'hFF, 0, 0, 1, 4, 1, 8'h52, 1, 0);
    step("rb_shift2",   0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'h29, 1, 0);
    step("rb_shift3",   0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'h14, 1, 0);
    step("rb_done",     0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'h0A, 0, 1);
    step("rb_after",    0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'h0A, 0, 0);
    // Left burst, length 12 clamped to 8
    step("load_ff",     0, 1, 3'b011, 8'hFF, 0, 0, 0, 0, 0, 8'hFF, 0, 0);
    step("cl_accept",   0, 1, 3'b000, 8'h00, 0, 0, 1, 12, 1, 8'hFF, 1, 0);
    step("cl_shift1",   0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'hFE, 1, 0);
    step("cl_shift2",   0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'hFC, 1, 0);
    step("cl_shift3",   0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'hF8, 1, 0);
    step("cl_shift4",   0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'hF0, 1, 0);
    step("cl_shift5",   0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'hE0, 1, 0);
    step("cl_shift6",   0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'hC0, 1, 0);
    step("cl_shift7",   0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'h80, 1, 0);
    step("cl_done",     0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1);
    step("cl_after",    0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    // Zero-length request: ignored, mode proceeds
    step("load_3c",     0, 1, 3'b011, 8'h3C, 0, 0, 0, 0, 0, 8'h3C, 0, 0);
    step("len0_shl",    0, 1, 3'b001, 8'h00, 1, 0, 1, 0, 0, 8'h79, 0, 0);
    step("len0_after",  0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'h79, 0, 0);
    // Right burst of 3 with a 2-cycle stall after the first shift
    step("st_accept",   0, 1, 3'b000, 8'h00, 0, 1, 1, 3, 0, 8'h79, 1, 0);
    step("st_shift1",   0, 1, 3'b000, 8'h00, 0, 1, 0, 0, 0, 8'hBC, 1, 0);
    step("st_stall1",   0, 0, 3'b011, 8'h00, 0, 1, 0, 0, 0, 8'hBC, 1, 0);
    step("st_stall2",   0, 0, 3'b011, 8'h00, 0, 1, 0, 0, 0, 8'hBC, 1, 0);
    step("st_shift2",   0, 1, 3'b000, 8'h00, 0, 1, 0, 0, 0, 8'hDE, 1, 0);
    step("st_done",     0, 1, 3'b000, 8'h00, 0, 1, 0, 0, 0, 8'hEF, 0, 1);
    step("st_after",    0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'hEF, 0, 0);
    // Reset on the second shift edge (with en low, reset still wins)
    step("ra_accept",   0, 1, 3'b000, 8'h00, 1, 0, 1, 4, 1, 8'hEF, 1, 0);
    step("ra_shift1",   0, 1, 3'b000, 8'h00, 1, 0, 0, 0, 0, 8'hDF, 1, 0);
    step("ra_reset",    1, 0, 3'b000, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0);
    step("ra_idle",     0, 1, 3'b000, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0);
    // Next burst accepted normally
    step("nb_accept",   0, 1, 3'b000, 8'h00, 1, 0, 1, 2, 1, 8'h00, 1, 0);
    step("nb_shift1",   0, 1, 3'b000, 8'h00, 1, 0, 0, 0, 0, 8'h01, 1, 0);
    step("nb_done",     0, 1, 3'b000, 8'h00, 1, 0, 0, 0, 0, 8'h03, 0, 1);
    step("nb_after",    0, 1, 3'b000, 8'h00, 0, 0, 0, 0, 0, 8'h03, 0, 0);

    // Drain the scoreboard with a bounded wait
    waited = 0;
    while (sb.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
